// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 16 ticks per bit, mid-bit sampling, 7/8 data bits, optional parity, 1/2 stop bits.
// data_valid is a one-clk pulse on the final stop-bit sample edge; there is no backpressure, and each frame overwrites the previous result.
module uart_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t     state;
  logic       rx_meta;
  logic       rx_sync;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic       stop_idx;
  logic [7:0] shreg;
  logic       cfg_len8;
  logic [1:0] cfg_par;
  logic       cfg_stop2;
  logic       par_err;
  logic       frm_err;
  logic       par_en;
  logic       last_bit;
  logic       stop_fe;

  assign par_en   = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  assign last_bit = cfg_len8 ? (bit_cnt == 3'd7) : (bit_cnt == 3'd6);
  assign stop_fe  = frm_err | ~rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      cfg_len8     <= 1'b0;
      cfg_par      <= '0;
      cfg_stop2    <= 1'b0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      data_valid <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state     <= START;
              rx_busy   <= 1'b1;
              os_cnt    <= '0;
              bit_cnt   <= '0;
              stop_idx  <= 1'b0;
              shreg     <= '0;
              par_err   <= 1'b0;
              frm_err   <= 1'b0;
              cfg_len8  <= data_length;
              cfg_par   <= parity_type;
              cfg_stop2 <= stop_bits;
            end
          end
          START: begin
            if (os_cnt == 4'd7) begin
              os_cnt <= '0;
              if (!rx_sync) begin
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          DATA: begin
            if (os_cnt == 4'd15) begin
              os_cnt  <= '0;
              // Shift in from the top so the first (LSB) bit lands in bit 0 after eight samples.
              shreg   <= {rx_sync, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) state <= par_en ? PARITY : STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          PARITY: begin
            if (os_cnt == 4'd15) begin
              os_cnt  <= '0;
              par_err <= ((^shreg) ^ rx_sync) == (cfg_par == 2'b10);
              state   <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          STOP: begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              if (cfg_stop2 && !stop_idx) begin
                stop_idx <= 1'b1;
                frm_err  <= stop_fe;
              end else begin
                data_out     <= cfg_len8 ? shreg : {1'b0, shreg[7:1]};
                parity_error <= par_err;
                frame_error  <= stop_fe;
                data_valid   <= 1'b1;
                if (stop_fe) begin
                  state <= WAIT_HIGH;
                end else begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
                end
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          WAIT_HIGH: begin
            if (rx_sync) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a frame-level reference model of the UART receiver.
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       data_length = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;

  int n_assert = 0;
  int n_fail = 0;
  int width_bad = 0;
  int tick_cnt = 0;
  logic prev_dv = 1'b0;
  logic [9:0] dv_q[$];

  uart_receiver dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .data_length(data_length), .parity_type(parity_type), .stop_bits(stop_bits),
    .data_out(data_out), .data_valid(data_valid), .parity_error(parity_error),
    .frame_error(frame_error), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      baud_tick = (tick_cnt == 0);
      tick_cnt = (tick_cnt + 1) % TICK_DIV;
    end
  end

  // Record every data_valid pulse with the result it presents.
  initial begin
    forever begin
      @(negedge clk);
      if (data_valid) begin
        dv_q.push_back({parity_error, frame_error, data_out});
        if (prev_dv) width_bad++;
      end
      prev_dv = data_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_parity(input logic [7:0] d, input logic len8, input logic [1:0] pt);
    int ones;
    ones = len8 ? $countones(d) : $countones(d[6:0]);
    // Parity bit that makes the total count of ones odd (odd mode) or even (even mode).
    if (pt == 2'b01) return (ones % 2 == 0);
    return (ones % 2 == 1);
  endfunction

  function automatic logic [9:0] model(input logic [7:0] d, input logic len8, input logic [1:0] pt,
                                       input logic stop2, input logic p, input logic s0, input logic s1);
    logic [7:0] dm;
    int ones;
    logic pe;
    logic fe;
    dm = len8 ? d : {1'b0, d[6:0]};
    ones = $countones(dm) + int'(p);
    pe = 1'b0;
    if (pt == 2'b01) pe = (ones % 2 == 0);
    if (pt == 2'b10) pe = (ones % 2 == 1);
    fe = !s0 || (stop2 && !s1);
    return {pe, fe, dm};
  endfunction

  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic len8, input logic [1:0] pt, input logic stop2,
                            input logic p, input logic s0, input logic s1, input logic scramble);
    data_length = len8;
    parity_type = pt;
    stop_bits = stop2;
    bit_out(1'b0);
    if (scramble) begin
      data_length = 1'($urandom_range(0, 1));
      parity_type = 2'($urandom_range(0, 3));
      stop_bits = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < (len8 ? 8 : 7); i++) bit_out(d[i]);
    if (pt == 2'b01 || pt == 2'b10) bit_out(p);
    bit_out(s0);
    if (stop2) bit_out(s1);
  endtask

  task automatic expect_frame(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = 'x;
    if (dv_q.size() != 0) got = dv_q.pop_front();
    check({tag, "_data"}, 32'(got[7:0]), 32'(exp[7:0]));
    check({tag, "_perr"}, 32'(got[9]), 32'(exp[9]));
    check({tag, "_ferr"}, 32'(got[8]), 32'(exp[8]));
  endtask

  initial begin
    logic [7:0] d;
    logic len8;
    logic [1:0] pt;
    logic stop2;
    logic p;
    logic s0;
    logic s1;
    int gap;

    repeat (5) @(negedge clk);
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_perr", 32'(parity_error), 0);
    check("rst_ferr", 32'(frame_error), 0);
    check("rst_busy", 32'(rx_busy), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("8n1_cnt", dv_q.size(), 1);
    expect_frame("8n1", model(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    bit_out(1'b1);
    bit_out(1'b1);
    check("8n1_idle_busy", 32'(rx_busy), 0);
    check("8n1_hold_data", 32'(data_out), 32'h A5);

    // 7E2 0x35, wrong then right parity bit
    send_frame(8'h35, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("7e2a_cnt", dv_q.size(), 1);
    expect_frame("7e2a", model(8'h35, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1));
    bit_out(1'b1);
    send_frame(8'h35, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("7e2b_cnt", dv_q.size(), 1);
    expect_frame("7e2b", model(8'h35, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1));
    bit_out(1'b1);

    // 8O1 0x00 with a low stop bit, then a 40-bit break
    send_frame(8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (40) bit_out(1'b0);
    check("break_cnt", dv_q.size(), 1);
    expect_frame("break", model(8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1));
    check("break_busy", 32'(rx_busy), 1);
    bit_out(1'b1);
    bit_out(1'b1);
    check("break_end_busy", 32'(rx_busy), 0);
    send_frame(8'h5C, 1'b1, 2'b01, 1'b0, good_parity(8'h5C, 1'b1, 2'b01), 1'b1, 1'b1, 1'b0);
    check("after_break_cnt", dv_q.size(), 1);
    expect_frame("after_break", model(8'h5C, 1'b1, 2'b01, 1'b0, good_parity(8'h5C, 1'b1, 2'b01), 1'b1, 1'b1));
    bit_out(1'b1);

    // False start: 4 ticks low
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    check("glitch_busy_hi", 32'(rx_busy), 1);
    rx = 1'b1;
    repeat (7 * TICK_DIV) @(negedge clk);
    check("glitch_busy_lo", 32'(rx_busy), 0);
    check("glitch_cnt", dv_q.size(), 0);

    // Reset during the 4th data bit of 0x5A
    data_length = 1'b1;
    parity_type = 2'b00;
    stop_bits = 1'b0;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'(8'h5A >> i));
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_data", 32'(data_out), 0);
    check("mrst_valid", 32'(data_valid), 0);
    check("mrst_perr", 32'(parity_error), 0);
    check("mrst_ferr", 32'(frame_error), 0);
    check("mrst_busy", 32'(rx_busy), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("mrst_cnt", dv_q.size(), 0);
    send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("post_rst_cnt", dv_q.size(), 1);
    expect_frame("post_rst", model(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    bit_out(1'b1);

    // Back-to-back 8N1
    send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_cnt", dv_q.size(), 2);
    expect_frame("b2b0", model(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    expect_frame("b2b1", model(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    bit_out(1'b1);

    // Random frames; config inputs scrambled after each start bit
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      len8 = 1'($urandom_range(0, 1));
      pt = 2'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
      p = good_parity(d, len8, pt) ^ ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 4) != 0);
      s1 = ($urandom_range(0, 4) != 0);
      send_frame(d, len8, pt, stop2, p, s0, s1, 1'b1);
      check($sformatf("rnd%0d_cnt", n), dv_q.size(), 1);
      expect_frame($sformatf("rnd%0d", n), model(d, len8, pt, stop2, p, s0, s1));
      gap = $urandom_range(0, 2);
      if (!s0 || (stop2 && !s1)) gap = gap + 1;
      for (int g = 0; g < gap; g++) bit_out(1'b1);
    end
    bit_out(1'b1);
    check("dv_width", width_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
